// File: rtl/sha2_pkg.sv
// Shared SHA-2 types, constants and sigma helpers used by the message schedule.
package sha2_pkg;

    typedef logic [31:0]  word_t;
    typedef logic [511:0] block_t;

    localparam int WORDS_PER_BLOCK = 16;
    localparam int SHA256_ROUNDS   = 64;

    typedef enum logic {
        IDLE,
        EXPAND
    } sched_state_t;

    function automatic word_t rotr(input word_t x, input int unsigned n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t sha256_sig0(input word_t x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction

    function automatic word_t sha256_sig1(input word_t x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction

endpackage

// File: rtl/message_schedule.sv
// SHA-256 message schedule expander: one 512-bit block in, W0..W63 out as a stream.
// Optional MESSAGE_SCHEDULE_PREFETCH_EN adds a pending block register for zero-bubble back-to-back blocks.
module message_schedule
    import sha2_pkg::*;
(
    input  logic         clk,
    input  logic         nrst,
    input  logic [511:0] data_in,
    input  logic         data_in_valid,
    output logic         data_in_ready,
    input  logic         data_in_last,
    output logic [31:0]  data_out,
    output logic [5:0]   data_out_index,
    output logic         data_out_valid,
    input  logic         data_out_ready,
    output logic         data_out_block_last,
    output logic         data_out_last
);

    localparam logic [5:0] LAST_T = 6'(SHA256_ROUNDS - 1);

    sched_state_t r_state;
    word_t        r_win [WORDS_PER_BLOCK];
    logic [5:0]   r_t;
    logic         r_last;

    logic   w_in_hs;
    logic   w_out_hs;
    logic   w_block_done;
    logic   w_load;
    block_t w_load_blk;
    logic   w_load_last;
    word_t  w_next_word;

    assign w_in_hs      = data_in_valid && data_in_ready;
    assign w_out_hs     = data_out_valid && data_out_ready;
    assign w_block_done = w_out_hs && (r_t == LAST_T);

    // Newest schedule word enters at w[15]; the window is the last 16 words.
    assign w_next_word = sha256_sig1(r_win[14]) + r_win[9] + sha256_sig0(r_win[1]) + r_win[0];

`ifdef MESSAGE_SCHEDULE_PREFETCH_EN
    block_t r_pend;
    logic   r_pend_valid;
    logic   r_pend_last;
    logic   w_pend_consume;
    logic   w_direct_load;

    assign data_in_ready  = !r_pend_valid;
    assign w_pend_consume = w_block_done && r_pend_valid;
    // A new block goes straight into the window when nothing is being expanded next.
    assign w_direct_load  = w_in_hs && ((r_state == IDLE) || (w_block_done && !r_pend_valid));
    assign w_load         = w_direct_load || w_pend_consume;
    assign w_load_blk     = w_pend_consume ? r_pend : data_in;
    assign w_load_last    = w_pend_consume ? r_pend_last : data_in_last;

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_pend       <= '0;
            r_pend_valid <= 1'b0;
            r_pend_last  <= 1'b0;
        end else if (w_in_hs && !w_direct_load) begin
            r_pend       <= data_in;
            r_pend_valid <= 1'b1;
            r_pend_last  <= data_in_last;
        end else if (w_pend_consume) begin
            r_pend_valid <= 1'b0;
        end
    end
`else
    assign data_in_ready = (r_state == IDLE);
    assign w_load        = w_in_hs;
    assign w_load_blk    = data_in;
    assign w_load_last   = data_in_last;
`endif

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            r_state <= IDLE;
            r_t     <= '0;
            r_last  <= 1'b0;
            // NOTE: the window is reset so data_out reads zero out of reset and no stale words survive.
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                r_win[i] <= '0;
            end
        end else if (w_load) begin
            r_state <= EXPAND;
            r_t     <= '0;
            r_last  <= w_load_last;
            for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
                r_win[i] <= w_load_blk[511 - 32*i -: 32];
            end
        end else if (w_out_hs) begin
            if (r_t == LAST_T) begin
                r_state <= IDLE;
                r_t     <= '0;
            end else begin
                r_t <= r_t + 6'd1;
                for (int i = 0; i < WORDS_PER_BLOCK - 1; i++) begin
                    r_win[i] <= r_win[i + 1];
                end
                r_win[WORDS_PER_BLOCK - 1] <= w_next_word;
            end
        end
    end

    assign data_out_valid      = (r_state == EXPAND);
    assign data_out            = r_win[0];
    assign data_out_index      = r_t;
    assign data_out_block_last = data_out_valid && (r_t == LAST_T);
    assign data_out_last       = data_out_block_last && r_last;

endmodule

// File: tb/tb_message_schedule.sv
// Self-checking bench for message_schedule: directed vectors, random stalls, back-to-back blocks, mid-block reset.
module tb_message_schedule;

    logic         clk = 1'b0;
    logic         nrst = 1'b0;
    logic [511:0] data_in = '0;
    logic         data_in_valid = 1'b0;
    logic         data_in_ready;
    logic         data_in_last = 1'b0;
    logic [31:0]  data_out;
    logic [5:0]   data_out_index;
    logic         data_out_valid;
    logic         data_out_ready = 1'b0;
    logic         data_out_block_last;
    logic         data_out_last;

    message_schedule dut (
        .clk                 (clk),
        .nrst                (nrst),
        .data_in             (data_in),
        .data_in_valid       (data_in_valid),
        .data_in_ready       (data_in_ready),
        .data_in_last        (data_in_last),
        .data_out            (data_out),
        .data_out_index      (data_out_index),
        .data_out_valid      (data_out_valid),
        .data_out_ready      (data_out_ready),
        .data_out_block_last (data_out_block_last),
        .data_out_last       (data_out_last)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [31:0] got   [64];
    logic [31:0] exp_w [64];

    typedef struct {
        string        name;
        logic [511:0] blk;
        bit           last;
        int           idx;
        logic [31:0]  w;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] rr(input logic [31:0] x, input int n);
        logic [63:0] d;
        d = {x, x} >> n;
        return d[31:0];
    endfunction

    function automatic logic [31:0] s0(input logic [31:0] x);
        return rr(x, 7) ^ rr(x, 18) ^ (x >> 3);
    endfunction

    function automatic logic [31:0] s1(input logic [31:0] x);
        return rr(x, 17) ^ rr(x, 19) ^ (x >> 10);
    endfunction

    // Reference schedule in the textbook W[t-2], W[t-7], W[t-15], W[t-16] form.
    task automatic model(input logic [511:0] b);
        for (int t = 0; t < 16; t++) exp_w[t] = b[511 - 32*t -: 32];
        for (int t = 16; t < 64; t++)
            exp_w[t] = s1(exp_w[t-2]) + exp_w[t-7] + s0(exp_w[t-15]) + exp_w[t-16];
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] b;
        for (int i = 0; i < 16; i++) b[32*i +: 32] = $urandom;
        return b;
    endfunction

    task automatic offer(input logic [511:0] b, input bit last);
        int k = 0;
        while (!data_in_ready && k < 200) begin
            @(negedge clk);
            k++;
        end
        check("in_ready_wait", 64'(data_in_ready), 64'd1);
        data_in       = b;
        data_in_last  = last;
        data_in_valid = 1'b1;
        @(negedge clk);
        data_in_valid = 1'b0;
    endtask

    // Collects up to nmax words; checks index, markers and stability across stalls.
    task automatic collect(input bit last, input bit rnd, input int nmax, output int cycles);
        int          n = 0;
        bit          stalled = 1'b0;
        logic [31:0] hold_d = '0;
        logic [5:0]  hold_i = '0;
        cycles = 0;
        while (n < nmax && cycles < 5000) begin
            data_out_ready = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            if (data_out_valid) begin
                if (stalled) begin
                    check("stall_data", 64'(data_out), 64'(hold_d));
                    check("stall_index", 64'(data_out_index), 64'(hold_i));
                end
                if (data_out_ready) begin
                    check("index", 64'(data_out_index), 64'(n));
                    check("block_last", 64'(data_out_block_last), 64'(n == 63));
                    check("msg_last", 64'(data_out_last), 64'(n == 63 && last));
`ifndef MESSAGE_SCHEDULE_PREFETCH_EN
                    if (n == 5) check("in_ready_busy", 64'(data_in_ready), 64'd0);
`endif
                    got[n]  = data_out;
                    n++;
                    stalled = 1'b0;
                end else begin
                    stalled = 1'b1;
                    hold_d  = data_out;
                    hold_i  = data_out_index;
                end
            end
            @(negedge clk);
            cycles++;
        end
        if (n < nmax) check("collect_timeout", 64'(n), 64'(nmax));
        data_out_ready = 1'b0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, 64'(data_out_valid), 64'd0);
        check({tag, "_data"}, 64'(data_out), 64'd0);
        check({tag, "_index"}, 64'(data_out_index), 64'd0);
        check({tag, "_block_last"}, 64'(data_out_block_last), 64'd0);
        check({tag, "_last"}, 64'(data_out_last), 64'd0);
        check({tag, "_in_ready"}, 64'(data_in_ready), 64'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        vec_t         vecs [6];
        logic [511:0] abc_blk;
        logic [511:0] b;
        logic [511:0] b2;
        int           cyc;
        int           cyc2;

        abc_blk = {32'h61626380, 448'h0, 32'h00000018};
        vecs[0] = '{"abc_w0",  abc_blk, 1'b1, 0,  32'h61626380};
        vecs[1] = '{"abc_w15", abc_blk, 1'b1, 15, 32'h00000018};
        vecs[2] = '{"abc_w16", abc_blk, 1'b1, 16, 32'h61626380};
        vecs[3] = '{"abc_w17", abc_blk, 1'b1, 17, 32'h000F0000};
        vecs[4] = '{"zero_w0", 512'h0,  1'b0, 0,  32'h00000000};
        vecs[5] = '{"zero_w63", 512'h0, 1'b0, 63, 32'h00000000};

        // Reset state
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        nrst = 1'b1;
        @(negedge clk);

        // Directed vectors, ready held high: 64 words in 64 cycles after accept
        for (int v = 0; v < 6; v++) begin
            offer(vecs[v].blk, vecs[v].last);
            collect(vecs[v].last, 1'b0, 64, cyc);
            check(vecs[v].name, 64'(got[vecs[v].idx]), 64'(vecs[v].w));
            check("words_cycles", 64'(cyc), 64'd64);
`ifndef MESSAGE_SCHEDULE_PREFETCH_EN
            check("bubble_valid", 64'(data_out_valid), 64'd0);
`endif
        end

        // All-zero block: every word zero
        offer(512'h0, 1'b0);
        collect(1'b0, 1'b0, 64, cyc);
        for (int t = 0; t < 64; t++) check("zero_word", 64'(got[t]), 64'd0);

        // Two blocks, last=0 then last=1
        b  = rand_block();
        b2 = rand_block();
        offer(b, 1'b0);
        collect(1'b0, 1'b0, 64, cyc);
`ifndef MESSAGE_SCHEDULE_PREFETCH_EN
        check("gap_valid", 64'(data_out_valid), 64'd0);
        check("gap_in_ready", 64'(data_in_ready), 64'd1);
`endif
        offer(b2, 1'b1);
        collect(1'b1, 1'b0, 64, cyc);
        model(b2);
        for (int t = 0; t < 64; t++) check("two_blk_word", 64'(got[t]), 64'(exp_w[t]));

`ifdef MESSAGE_SCHEDULE_PREFETCH_EN
        // Second block offered mid-expansion must follow W63 with no gap
        b  = rand_block();
        b2 = rand_block();
        offer(b, 1'b0);
        fork
            collect(1'b0, 1'b0, 64, cyc);
            begin
                repeat (10) @(negedge clk);
                offer(b2, 1'b1);
            end
        join
        collect(1'b1, 1'b0, 64, cyc2);
        check("prefetch_no_gap", 64'(cyc2), 64'd64);
        model(b2);
        for (int t = 0; t < 64; t++) check("prefetch_word", 64'(got[t]), 64'(exp_w[t]));
`endif

        // Random blocks with random downstream stalls
        for (int i = 0; i < 100; i++) begin
            b = rand_block();
            model(b);
            offer(b, i[0]);
            collect(i[0], 1'b1, 64, cyc);
            for (int t = 0; t < 64; t++) check("rand_word", 64'(got[t]), 64'(exp_w[t]));
        end

        // Reset with t==30 on the output, then a fresh block from W0
        b = rand_block();
        offer(b, 1'b1);
        collect(1'b1, 1'b0, 30, cyc);
        check("pre_reset_index", 64'(data_out_index), 64'd30);
        nrst = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        check("post_reset_valid", 64'(data_out_valid), 64'd0);
        b = rand_block();
        model(b);
        offer(b, 1'b0);
        collect(1'b0, 1'b0, 64, cyc);
        for (int t = 0; t < 64; t++) check("post_reset_word", 64'(got[t]), 64'(exp_w[t]));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
